// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for the decode stage: condition compare, target
// select, a circular return-address stack and saturating statistics counters.
//
// Handshake: an instruction is accepted on a rising edge when valid=1,
// stall=0 and reset=0. Only accepted instructions change registered state
// (RAS, counters). All combinational outputs ignore valid/stall/reset.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     pc_plus_four,
    input  logic [WIDTH-1:0]     maybe_jump_address,
    input  logic [WIDTH-1:0]     maybe_branch_address,
    input  logic [WIDTH-1:0]     reg_rs,
    input  logic [WIDTH-1:0]     reg_rt,
    input  logic                 blt,
    input  logic                 beq,
    input  logic                 bgt,
    input  logic                 signed_cmp,
    input  logic                 link_reg,
    input  logic                 rt_is_zero,
    input  logic                 is_r_type,
    input  logic                 is_i_type,
    input  logic                 is_j_type,
    input  logic                 is_return,
    output logic [WIDTH-1:0]     jump_address,
    output logic                 pc_src,
    output logic                 branch,
    output logic                 ra_write,
    output logic [WIDTH-1:0]     ra_write_value,
    output logic [WIDTH-1:0]     ras_top,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_predict_ok,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] taken_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] correct_rt;
    logic             rs_lt;
    logic             rs_eq;
    logic             rs_gt;
    logic             accept;
    logic             ras_push;
    logic             ras_pop;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [CW-1:0]    ras_count;
    logic [PW-1:0]    ras_ptr_inc;

    // Operand compare, signed or unsigned, against rt or forced zero
    always_comb begin
        correct_rt = rt_is_zero ? '0 : reg_rt;
        rs_eq      = (reg_rs == correct_rt);
        if (signed_cmp) begin
            rs_lt = $signed(reg_rs) < $signed(correct_rt);
            rs_gt = $signed(reg_rs) > $signed(correct_rt);
        end else begin
            rs_lt = reg_rs < correct_rt;
            rs_gt = reg_rs > correct_rt;
        end
    end

    assign pc_src         = (blt & rs_lt) | (beq & rs_eq) | (bgt & rs_gt);
    assign branch         = blt | beq | bgt;
    assign ra_write       = pc_src & link_reg;
    assign ra_write_value = pc_plus_four;

    // Target select: register beats relative beats absolute; zero when untyped
    always_comb begin
        jump_address = '0;
        if (is_r_type)      jump_address = reg_rs;
        else if (is_i_type) jump_address = maybe_branch_address;
        else if (is_j_type) jump_address = maybe_jump_address;
    end

    assign accept      = valid & ~stall & ~reset;
    assign ras_empty   = (ras_count == '0);
    assign ras_full    = (ras_count == CW'(RAS_DEPTH));
    assign ras_top     = ras_empty ? '0 : ras_mem[ras_ptr];
    assign ras_push    = accept & ra_write;
    assign ras_pop     = accept & is_return & is_r_type & pc_src & ~ras_empty;
    assign ras_ptr_inc = ras_ptr + PW'(1);

    assign ras_predict_ok = is_return & ~ras_empty & (ras_top == reg_rs);

    // RAS update: push wraps over the oldest entry, pop on empty is blocked,
    // push+pop together rewrites the top entry in place
    always_ff @(posedge clock) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
            for (int k = 0; k < RAS_DEPTH; k++) ras_mem[k] <= '0;
        end else if (ras_push && ras_pop) begin
            ras_mem[ras_ptr] <= pc_plus_four;
        end else if (ras_push) begin
            ras_mem[ras_ptr_inc] <= pc_plus_four;
            ras_ptr              <= ras_ptr_inc;
            if (!ras_full) ras_count <= ras_count + CW'(1);
        end else if (ras_pop) begin
            ras_ptr   <= ras_ptr - PW'(1);
            ras_count <= ras_count - CW'(1);
        end
    end

    // Saturating performance counters for accepted branches and taken branches
    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            if (accept && branch && !(&branch_count)) branch_count <= branch_count + CNT_WIDTH'(1);
            if (accept && pc_src && !(&taken_count))  taken_count  <= taken_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: combinational vector table, directed RAS and
// counter sequences, then randomized traffic against a queue-based model.
module tb_branch_resolve_unit;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clock;
    logic          reset;
    logic          valid;
    logic          stall;
    logic [W-1:0]  pc_plus_four;
    logic [W-1:0]  maybe_jump_address;
    logic [W-1:0]  maybe_branch_address;
    logic [W-1:0]  reg_rs;
    logic [W-1:0]  reg_rt;
    logic          blt, beq, bgt, signed_cmp, link_reg, rt_is_zero;
    logic          is_r_type, is_i_type, is_j_type, is_return;
    logic [W-1:0]  jump_address;
    logic          pc_src, branch, ra_write;
    logic [W-1:0]  ra_write_value;
    logic [W-1:0]  ras_top;
    logic          ras_empty, ras_full, ras_predict_ok;
    logic [CW-1:0] branch_count, taken_count;

    branch_resolve_unit #(.WIDTH(W), .RAS_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .valid(valid), .stall(stall),
        .pc_plus_four(pc_plus_four), .maybe_jump_address(maybe_jump_address),
        .maybe_branch_address(maybe_branch_address), .reg_rs(reg_rs), .reg_rt(reg_rt),
        .blt(blt), .beq(beq), .bgt(bgt), .signed_cmp(signed_cmp), .link_reg(link_reg),
        .rt_is_zero(rt_is_zero), .is_r_type(is_r_type), .is_i_type(is_i_type),
        .is_j_type(is_j_type), .is_return(is_return), .jump_address(jump_address),
        .pc_src(pc_src), .branch(branch), .ra_write(ra_write), .ra_write_value(ra_write_value),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_predict_ok(ras_predict_ok), .branch_count(branch_count), .taken_count(taken_count)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- types ----------------
    typedef struct {
        logic         valid, stall;
        logic [W-1:0] pc4, jaddr, baddr, rs, rt;
        logic         blt, beq, bgt, sc, link, rz, r, i, j, ret;
    } insn_t;

    typedef struct {
        logic [W-1:0] rs, rt;
        logic         blt, beq, bgt, sc, rz, r, i, j;
        logic         exp_pc_src, exp_branch;
        logic [W-1:0] exp_jump;
    } vec_t;

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];     // model RAS, oldest first, top at the back
    int           m_bc, m_tc;   // model counters
    int           total, bad;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pc_src(insn_t x);
        longint a, b;
        logic [W-1:0] rt_eff;
        rt_eff = x.rz ? '0 : x.rt;
        if (x.sc) begin
            a = longint'($signed(x.rs));
            b = longint'($signed(rt_eff));
        end else begin
            a = longint'(x.rs);
            b = longint'(rt_eff);
        end
        return (x.blt && a < b) || (x.beq && a == b) || (x.bgt && a > b);
    endfunction

    function automatic logic [W-1:0] m_jump(insn_t x);
        if (x.r) return x.rs;
        if (x.i) return x.baddr;
        if (x.j) return x.jaddr;
        return '0;
    endfunction

    function automatic logic [W-1:0] m_top();
        return (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
    endfunction

    function automatic insn_t idle_insn();
        insn_t x;
        x.valid = 0; x.stall = 0; x.pc4 = '0; x.jaddr = '0; x.baddr = '0;
        x.rs = '0; x.rt = '0; x.blt = 0; x.beq = 0; x.bgt = 0; x.sc = 0;
        x.link = 0; x.rz = 0; x.r = 0; x.i = 0; x.j = 0; x.ret = 0;
        return x;
    endfunction

    function automatic insn_t jal(input logic [W-1:0] pc4);
        insn_t x = idle_insn();
        x.valid = 1; x.beq = 1; x.rz = 1; x.link = 1; x.j = 1; x.pc4 = pc4; x.jaddr = 32'h4000;
        return x;
    endfunction

    function automatic insn_t jr_ra(input logic [W-1:0] rs);
        insn_t x = idle_insn();
        x.valid = 1; x.beq = 1; x.rs = rs; x.rt = rs; x.r = 1; x.ret = 1; x.pc4 = 32'h900;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(insn_t x);
        valid = x.valid; stall = x.stall; pc_plus_four = x.pc4;
        maybe_jump_address = x.jaddr; maybe_branch_address = x.baddr;
        reg_rs = x.rs; reg_rt = x.rt; blt = x.blt; beq = x.beq; bgt = x.bgt;
        signed_cmp = x.sc; link_reg = x.link; rt_is_zero = x.rz;
        is_r_type = x.r; is_i_type = x.i; is_j_type = x.j; is_return = x.ret;
    endtask

    // Drive one instruction, check every output against the model, clock it.
    task automatic cycle(insn_t x);
        logic pc, acc, push, pop;
        apply(x);
        #1;
        pc = m_pc_src(x);
        check("pc_src", W'(pc_src), W'(pc));
        check("branch", W'(branch), W'(x.blt | x.beq | x.bgt));
        check("ra_write", W'(ra_write), W'(pc & x.link));
        check("ra_write_value", ra_write_value, x.pc4);
        check("jump_address", jump_address, m_jump(x));
        check("ras_top", ras_top, m_top());
        check("ras_empty", W'(ras_empty), W'(exp_q.size() == 0));
        check("ras_full", W'(ras_full), W'(exp_q.size() == DEPTH));
        check("ras_predict_ok", W'(ras_predict_ok),
              W'(x.ret && exp_q.size() != 0 && m_top() == x.rs));
        check("branch_count", W'(branch_count), W'(m_bc));
        check("taken_count", W'(taken_count), W'(m_tc));
        acc  = x.valid && !x.stall && !reset;
        push = acc && pc && x.link;
        pop  = acc && x.ret && x.r && pc && exp_q.size() != 0;
        if (reset) begin
            exp_q.delete();
            m_bc = 0;
            m_tc = 0;
        end else begin
            if (push && pop) exp_q[exp_q.size()-1] = x.pc4;
            else if (push) begin
                exp_q.push_back(x.pc4);
                if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            end else if (pop) void'(exp_q.pop_back());
            if (acc && (x.blt | x.beq | x.bgt)) m_bc = (m_bc + 1 > 15) ? 15 : m_bc + 1;
            if (acc && pc) m_tc = (m_tc + 1 > 15) ? 15 : m_tc + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(idle_insn());
        reset = 1'b0;
    endtask

    // ---------------- test ----------------
    vec_t  vecs[10];
    insn_t t;

    initial begin
        total = 0; bad = 0; m_bc = 0; m_tc = 0;
        reset = 1'b1;
        apply(idle_insn());
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst ras_empty", W'(ras_empty), 32'd1);
        check("rst ras_full", W'(ras_full), 32'd0);
        check("rst ras_top", ras_top, 32'd0);
        check("rst branch_count", W'(branch_count), 32'd0);
        check("rst taken_count", W'(taken_count), 32'd0);

        // Combinational vector table (valid=0, no state change)
        //           rs            rt            blt beq bgt sc rz r i j pc br jump
        vecs[0] = '{32'hFFFF_FFFF, 32'h1,        1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1,        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0};
        vecs[2] = '{32'h5,         32'h5,        0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 32'h5};
        vecs[3] = '{32'h5,         32'h7,        0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 32'hBBBB};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 32'hAAAA_0000};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0};
        vecs[6] = '{32'h3,         32'h9,        0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0};
        vecs[7] = '{32'h3,         32'h9,        0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h3};
        vecs[8] = '{32'h0,         32'h1234,     0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 32'h0};
        vecs[9] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 32'hBBBB};
        for (int k = 0; k < 10; k++) begin
            t = idle_insn();
            t.rs = vecs[k].rs; t.rt = vecs[k].rt; t.blt = vecs[k].blt; t.beq = vecs[k].beq;
            t.bgt = vecs[k].bgt; t.sc = vecs[k].sc; t.rz = vecs[k].rz; t.r = vecs[k].r;
            t.i = vecs[k].i; t.j = vecs[k].j; t.jaddr = 32'hAAAA_0000; t.baddr = 32'hBBBB;
            t.pc4 = 32'h100 + k;
            apply(t);
            #1;
            check($sformatf("vec%0d pc_src", k), W'(pc_src), W'(vecs[k].exp_pc_src));
            check($sformatf("vec%0d branch", k), W'(branch), W'(vecs[k].exp_branch));
            check($sformatf("vec%0d jump", k), jump_address, vecs[k].exp_jump);
        end
        cycle(idle_insn());

        // Call / return
        cycle(jal(32'h104));
        check("call ras_top", ras_top, 32'h104);
        check("call ras_empty", W'(ras_empty), 32'd0);
        apply(jr_ra(32'h104));
        #1;
        check("ret predict_ok", W'(ras_predict_ok), 32'd1);
        cycle(jr_ra(32'h104));
        check("ret ras_empty", W'(ras_empty), 32'd1);

        // Stall and underflow
        do_reset();
        cycle(jr_ra(32'h55));
        check("underflow ras_empty", W'(ras_empty), 32'd1);
        check("underflow ras_top", ras_top, 32'd0);
        t = jal(32'h77);
        t.stall = 1;
        cycle(t);
        check("stall ras_empty", W'(ras_empty), 32'd1);
        check("stall branch_count", W'(branch_count), 32'd1);

        // Overflow / wrap
        for (int k = 1; k <= 5; k++) cycle(jal(W'(k * 16)));
        check("ovf ras_full", W'(ras_full), 32'd1);
        check("ovf ras_top", ras_top, 32'h50);
        cycle(jr_ra(32'h50)); check("pop1 top", ras_top, 32'h40);
        cycle(jr_ra(32'h40)); check("pop2 top", ras_top, 32'h30);
        cycle(jr_ra(32'h30)); check("pop3 top", ras_top, 32'h20);
        cycle(jr_ra(32'h20)); check("pop4 empty", W'(ras_empty), 32'd1);

        // jalr $ra: push+pop rewrites top in place
        cycle(jal(32'h200));
        t = jr_ra(32'h200); t.link = 1; t.pc4 = 32'h300;
        cycle(t);
        check("jalr top", ras_top, 32'h300);
        check("jalr not full", W'(ras_full), 32'd0);

        // Counter saturation
        do_reset();
        t = idle_insn(); t.valid = 1; t.beq = 1; t.rs = 32'h5; t.rt = 32'h5;
        repeat (20) cycle(t);
        check("sat branch_count", W'(branch_count), 32'hF);
        check("sat taken_count", W'(taken_count), 32'hF);

        // Reset mid-operation with a simultaneous push
        cycle(jal(32'h11)); cycle(jal(32'h22)); cycle(jal(32'h33));
        reset = 1'b1;
        cycle(jal(32'h44));
        reset = 1'b0;
        check("midrst ras_empty", W'(ras_empty), 32'd1);
        check("midrst ras_top", ras_top, 32'd0);
        check("midrst branch_count", W'(branch_count), 32'd0);
        check("midrst taken_count", W'(taken_count), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            t = idle_insn();
            t.valid = ($urandom_range(0, 3) != 0);
            t.stall = ($urandom_range(0, 4) == 0);
            t.pc4   = $urandom_range(1, 255) << 2;
            t.jaddr = $urandom; t.baddr = $urandom;
            case ($urandom_range(0, 4))
                0: t.rs = 32'h0;
                1: t.rs = 32'hFFFF_FFFF;
                2: t.rs = 32'h8000_0000;
                3: t.rs = m_top();
                default: t.rs = $urandom;
            endcase
            t.rt  = ($urandom_range(0, 2) == 0) ? t.rs : $urandom;
            t.blt = $urandom_range(0, 1); t.beq = $urandom_range(0, 1); t.bgt = $urandom_range(0, 1);
            t.sc  = $urandom_range(0, 1); t.rz = ($urandom_range(0, 3) == 0);
            t.link = $urandom_range(0, 1);
            t.r = $urandom_range(0, 1); t.i = $urandom_range(0, 1); t.j = $urandom_range(0, 1);
            t.ret = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 60) == 0);
            cycle(t);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
